// File: rtl/ram_banked.sv
// ram_banked: banked single-port RAM with self-initialisation.
// After reset the block zeroes every word (all banks in parallel, one local
// address per cycle) while busy is high, then serves one read or write per
// cycle. Reads have one cycle of latency.
// Ports:
//   ck       - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset, restarts initialisation
//   en       - access request
//   wen      - 1 = write, 0 = read (only while en=1)
//   addr     - word address, upper BB bits select the bank
//   din      - write data
//   dout     - registered read data, holds between reads
//   dout_vld - dout carries the read accepted on the previous edge
//   busy     - initialisation in progress, requests ignored
module ram_banked #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 6,
   parameter int unsigned BB = 2
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          en,
   input  logic          wen,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          busy
);

   localparam int unsigned LW = AW - BB;
   localparam int unsigned LD = 1 << LW;
   localparam int unsigned NB = 1 << BB;
   localparam int unsigned BW = (BB > 0) ? BB : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t          state, state_nx;
   logic [LW-1:0]   cnt;
   logic [LW-1:0]   loc;
   logic [BW-1:0]   bank;
   logic            init_we, run_we, rd_en;
   logic [DW-1:0]   rd_word [NB];

   assign loc  = addr[LW-1:0];
   // Shift rather than slice so BB=0 collapses to a single bank index of 0.
   assign bank = en ? BW'(addr >> LW) : '0;

   // State register
   always_ff @(posedge ck) begin
      if (rst) state <= INIT;
      else     state <= state_nx;
   end

   // Next-state logic: leave INIT on the edge that clears the last word
   always_comb begin
      state_nx = state;
      case (state)
         INIT:    if (cnt == '1) state_nx = RUN;
         RUN:     state_nx = RUN;
         default: state_nx = INIT;
      endcase
   end

   // Output / strobe decode; nothing is written while rst is sampled
   always_comb begin
      busy    = (state == INIT);
      init_we = (state == INIT) && !rst;
      run_we  = (state == RUN) && en && wen && !rst;
      rd_en   = (state == RUN) && en && !wen && !rst;
   end

   // Initialisation counter parks at its last value once RUN is reached
   always_ff @(posedge ck) begin
      if (rst)
         cnt <= '0;
      else if (state == INIT && cnt != '1)
         cnt <= cnt + 1'b1;
   end

   for (genvar g = 0; g < NB; g++) begin : g_bank
      logic [DW-1:0] mem [LD];
      logic          sel;

      assign sel = (bank == BW'(g));

      always_ff @(posedge ck) begin
         if (init_we)
            mem[cnt] <= '0;
         else if (run_we && sel)
            mem[loc] <= din;
      end

      assign rd_word[g] = mem[loc];
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else begin
         dout_vld <= rd_en;
         if (rd_en) dout <= rd_word[bank];
      end
   end

endmodule

// File: tb/tb_ram_banked.sv
// Directed plus random test of ram_banked against a flat-array model.
module tb_ram_banked;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 6;
   localparam int unsigned BB = 2;
   localparam int unsigned INIT_CYC = 1 << (AW - BB);

   logic          ck = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          wen = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          busy;

   ram_banked #(.DW(DW), .AW(AW), .BB(BB)) dut (
      .ck(ck), .rst(rst), .en(en), .wen(wen), .addr(addr), .din(din),
      .dout(dout), .dout_vld(dout_vld), .busy(busy)
   );

   always #5 ck = ~ck;

   // Reference model: one flat word array plus expected outputs
   logic [DW-1:0] model [1 << AW];
   logic [DW-1:0] exp_dout;
   logic          exp_vld;
   logic          exp_busy;
   int            init_left;
   int            n_vec;
   int            n_err;

   task automatic model_edge(input logic r, input logic e, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (r) begin
         foreach (model[i]) model[i] = '0;
         init_left = INIT_CYC;
         exp_dout  = '0;
         exp_vld   = 1'b0;
      end else if (init_left > 0) begin
         init_left--;
         exp_vld = 1'b0;
      end else if (e && w) begin
         model[a] = d;
         exp_vld  = 1'b0;
      end else if (e) begin
         exp_dout = model[a];
         exp_vld  = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
      exp_busy = r || (init_left > 0);
   endtask

   task automatic check(input string tag);
      n_vec++;
      assert (dout === exp_dout) else begin
         n_err++;
         $error("FAIL %s dout: got %h expected %h", tag, dout, exp_dout);
      end
      n_vec++;
      assert (dout_vld === exp_vld) else begin
         n_err++;
         $error("FAIL %s dout_vld: got %b expected %b", tag, dout_vld, exp_vld);
      end
      n_vec++;
      assert (busy === exp_busy) else begin
         n_err++;
         $error("FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic e, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      rst = r; en = e; wen = w; addr = a; din = d;
      @(posedge ck);
      model_edge(r, e, w, a, d);
      #1;
      check(tag);
   endtask

   task automatic do_reset(input string tag);
      step(tag, 1'b1, 1'b1, 1'b1, AW'($urandom), DW'($urandom));
   endtask

   task automatic init_idle(input string tag);
      for (int i = 0; i < int'(INIT_CYC); i++) step(tag, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; init_left = 0;
      exp_dout = '0; exp_vld = 1'b0; exp_busy = 1'b1;
      foreach (model[i]) model[i] = '0;
      @(negedge ck);

      // Power-up initialisation with junk requests during INIT
      do_reset("reset");
      for (int i = 0; i < int'(INIT_CYC); i++)
         step("init_junk", 1'b0, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
      for (int a = 0; a < (1 << AW); a++) step("read_zero", 1'b0, 1'b1, 1'b0, AW'(a), '0);

      // Writes across banks, reads back-to-back in reverse order
      step("wr", 1'b0, 1'b1, 1'b1, 6'h00, 8'hA5);
      step("wr", 1'b0, 1'b1, 1'b1, 6'h10, 8'h3C);
      step("wr", 1'b0, 1'b1, 1'b1, 6'h20, 8'hFF);
      step("wr", 1'b0, 1'b1, 1'b1, 6'h3F, 8'h81);
      step("rd_3f", 1'b0, 1'b1, 1'b0, 6'h3F, '0);
      step("rd_20", 1'b0, 1'b1, 1'b0, 6'h20, '0);
      step("rd_10", 1'b0, 1'b1, 1'b0, 6'h10, '0);
      step("rd_00", 1'b0, 1'b1, 1'b0, 6'h00, '0);

      // Bank isolation
      step("wr_05", 1'b0, 1'b1, 1'b1, 6'h05, 8'h55);
      step("iso_15", 1'b0, 1'b1, 1'b0, 6'h15, '0);
      step("iso_25", 1'b0, 1'b1, 1'b0, 6'h25, '0);
      step("iso_35", 1'b0, 1'b1, 1'b0, 6'h35, '0);
      step("iso_05", 1'b0, 1'b1, 1'b0, 6'h05, '0);

      // Write then immediate read of same address
      step("wr_raw", 1'b0, 1'b1, 1'b1, 6'h2B, 8'h6E);
      step("rd_raw", 1'b0, 1'b1, 1'b0, 6'h2B, '0);

      // Hold and idle
      step("rd_10b", 1'b0, 1'b1, 1'b0, 6'h10, '0);
      for (int i = 0; i < 5; i++) step("idle_hold", 1'b0, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      step("wr_11", 1'b0, 1'b1, 1'b1, 6'h11, 8'h77);
      step("after_wr", 1'b0, 1'b0, 1'b0, '0, '0);
      step("rd_11", 1'b0, 1'b1, 1'b0, 6'h11, '0);

      // Requests during INIT are ignored
      do_reset("reset2");
      for (int i = 0; i < int'(INIT_CYC); i++) step("init_req", 1'b0, 1'b1, 1'b1, 6'h07, 8'h99);
      step("rd_07", 1'b0, 1'b1, 1'b0, 6'h07, '0);

      // Reset mid-RUN clears memory and output
      step("wr_2a", 1'b0, 1'b1, 1'b1, 6'h2A, 8'hC3);
      step("rd_2a_pre", 1'b0, 1'b1, 1'b0, 6'h2A, '0);
      do_reset("reset3");
      init_idle("init3");
      step("rd_2a", 1'b0, 1'b1, 1'b0, 6'h2A, '0);

      // Reset held for several edges, then reset mid-INIT
      for (int i = 0; i < 3; i++) do_reset("rst_hold");
      for (int i = 0; i < 5; i++) step("init4", 1'b0, 1'b0, 1'b0, '0, '0);
      do_reset("rst_mid_init");
      init_idle("init5");

      // Random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         logic r;
         r = ($urandom_range(0, 99) == 0);
         step("rand", r, 1'($urandom_range(0, 3) != 0), 1'($urandom),
              AW'($urandom), DW'($urandom));
      end
      for (int a = 0; a < (1 << AW); a++) step("final_rd", 1'b0, 1'b1, 1'b0, AW'(a), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_banked.md
RAM_BANKED -- requirements
Module: ram_banked

Interface
REQ-001 Parameter DW, default 8: data word width in bits; legal range 1..64.
REQ-002 Parameter AW, default 6: address width; total depth is 2^AW words.
REQ-003 Parameter BB, default 2: bank-select bits; bank count is 2^BB; legal range 0..AW-1.
REQ-004 ck  input  1: the single clock; all state changes on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset, sampled on the rising edge of ck.
REQ-006 en  input  1: access request, qualified on each rising edge.
REQ-007 wen  input  1: 1 = write, 0 = read; meaningful only while en=1.
REQ-008 addr  input  AW: word address; addr[AW-1:AW-BB] selects the bank, addr[AW-BB-1:0] is the local address.
REQ-009 din  input  DW: write data.
REQ-010 dout  output  DW: registered read data.
REQ-011 dout_vld  output  1: dout carries the result of the read accepted on the previous edge.
REQ-012 busy  output  1: the block is in initialisation; requests are ignored.

Function
REQ-013 The block SHALL hold 2^BB banks, each 2^(AW-BB) words of DW bits, all clocked by ck.
REQ-014 The FSM SHALL have two states: INIT and RUN.
REQ-015 INIT behaviour:
- A local counter cnt (AW-BB bits) starts at 0.
- Each cycle, zero is written at local address cnt in every bank at once, then cnt increments.
- When cnt equals 2^(AW-BB)-1, that write completes, cnt stays there and the FSM moves to RUN on the same edge.
- INIT therefore lasts exactly 2^(AW-BB) cycles (16 cycles with default parameters).
REQ-016 busy SHALL be 1 in INIT and 0 in RUN; busy is a registered output.
REQ-017 In INIT, en, wen, addr and din SHALL be ignored: no write occurs, dout_vld=0, and dout holds 0.
REQ-018 Write in RUN (en=1, wen=1 at edge N):
- din is written to the selected bank at the local address on edge N.
- No other bank is modified.
- dout_vld=0 after edge N, and dout holds its previous value.
REQ-019 Read in RUN (en=1, wen=0 at edge N):
- The addressed word is registered into dout on edge N.
- dout_vld=1 in the cycle after edge N; read latency is 1 cycle.
REQ-020 Idle in RUN (en=0): no write occurs, dout holds its value and dout_vld=0 after the edge.
REQ-021 A write at edge N followed by a read of the same address at edge N+1 SHALL return the new data after edge N+1.
REQ-022 Back-to-back reads on consecutive edges SHALL produce dout_vld=1 on every following cycle, one new word per cycle.
REQ-023 The bank-select field is decoded only when en=1.
- The write enable reaches exactly one bank, and only for a RUN write.
- Reads select the output of the bank registered with the request, so a bank change between consecutive reads causes no corruption.
REQ-024 When BB=0, the block SHALL behave as a single bank of depth 2^AW.
REQ-025 Addresses SHALL wrap naturally within AW bits; no out-of-range condition exists.

Reset
REQ-026 When rst=1 at an edge:
- FSM returns to INIT and cnt resets to 0.
- dout becomes 0, dout_vld becomes 0 and busy becomes 1.
- Any request sampled on that edge is discarded.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL restart the full initialisation, so every word reads 0 after busy falls.
REQ-028 While rst is held at 1, the block SHALL stay in INIT with cnt=0, and no memory location is written other than local address 0.

Verification
REQ-029 Initialisation with default parameters: rst=1 for 1 edge, then 0 -> busy=1 for exactly 16 cycles, then busy=0; reading all 64 addresses returns 0x00 with dout_vld=1.
REQ-030 Write then read: write 0xA5 to addr 0x00, 0x3C to 0x10, 0xFF to 0x20 and 0x81 to 0x3F; read back in the order 0x3F, 0x20, 0x10, 0x00 on consecutive edges -> dout sequence 0x81, 0xFF, 0x3C, 0xA5 with dout_vld=1 on four consecutive cycles.
REQ-031 Bank isolation: write 0x55 to addr 0x05 -> reading 0x15, 0x25 and 0x35 returns 0x00, and reading 0x05 returns 0x55.
REQ-032 Requests during INIT: en=1, wen=1, addr=0x07, din=0x99 during cycles 1..16 after reset -> after busy falls, reading 0x07 returns 0x00 and dout_vld stays 0 throughout INIT.
REQ-033 Reset mid-RUN: write 0xC3 to addr 0x2A, assert rst for one edge -> dout=0, dout_vld=0, busy=1 for 16 cycles, then reading 0x2A returns 0x00.
REQ-034 Hold and idle: read 0x10 (value 0x3C), then en=0 for 5 cycles -> dout stays 0x3C and dout_vld=0 during those 5 cycles; a write to 0x11 does not change dout.
